seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
// Reads back a multiplexed, active-low 7-segment display bus (segment lines + digit selects) and recovers the BCD value shown.
// Segment order is a..g with Seg_n[6]=a and Seg_n[0]=g; 0 = segment lit.
// Sits beside the BCD-to-segment driver, as its inverse, for self-check and loop-back of the display path.
// Each digit is captured only after its pattern has been stable; a frame is published once every digit has been captured.
// PARAMETERS
// DIGITS      4   number of multiplexed digits (1..8)
// STABLE_CYC  8   consecutive identical synced samples required before capture (2..15)
// PORTS
// Clk        in   1          system clock, rising edge
// Rst_n      in   1          asynchronous active-low reset
// Seg_n      in   7          segment lines a..g, active-low, asynchronous to Clk
// Dig_n      in   DIGITS     digit selects, active-low one-hot; bit i = digit i (digit 0 = least significant)
// Bcd_out    out  4*DIGITS   published value; nibble i = digit i
// Err_out    out  DIGITS     bit i = 1: digit i pattern in last frame was not a legal 0-9 glyph
// Frame_vld  out  1          1-cycle pulse when Bcd_out/Err_out update
// Busy       out  1          1 while a digit pattern is settling (state SETTLE)
// BEHAVIOUR
// - Reset (async, Rst_n=0): Bcd_out=0, Err_out=0, Frame_vld=0, Busy=0, state=IDLE, seen mask=0, counter=0, sync flops=all 1s.
// - Input sync: Seg_n and Dig_n each pass a 2-flop synchronizer. All rules below apply to the synced values (s_seg, s_dig).
// - Select valid: exactly one bit of s_dig is 0. Index = position of that bit.
// - FSM:
//   IDLE: select invalid. On a valid select -> SETTLE; latch s_seg/s_dig; cnt=1.
//   SETTLE: if select is invalid -> IDLE, cnt=0.
//     Else if s_seg or s_dig differs from latched value -> stay in SETTLE; re-latch; cnt=1.
//     Else cnt++; when cnt reaches STABLE_CYC -> capture at that edge, then -> HOLD.
//   HOLD: no recapture while s_seg/s_dig equal the latched value.
//     On change to another valid select or pattern -> SETTLE, re-latch, cnt=1.
//     On invalid select -> IDLE.
// - Capture latency: capture on the STABLE_CYC-th consecutive equal synced sample.
//   Worst case is 2 + STABLE_CYC clocks after the pins settle.
// - Decode (pattern -> nibble):
//   0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4,
//   0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
//   Any other pattern (including blank 1111111) -> nibble 4'hF, err=1.
// - Capture writes a shadow nibble and shadow err bit for the digit index, and sets seen[index].
//   Recapturing a digit already in seen overwrites its shadow; seen is unchanged.
// - Frame publish: on the edge after a capture makes seen all-ones:
//   Bcd_out<=shadow, Err_out<=shadow err, Frame_vld=1 for exactly that cycle, seen<=0.
//   A capture on the publish edge is applied after the clear, so it counts toward the next frame.
// - Outputs hold their last published value between frames.
// - Reset mid-settle or mid-frame discards partial shadow/seen contents; no Frame_vld pulse.
// - Busy = (state==SETTLE), registered.
// TESTING
// 1 Reset: Rst_n low while the bus toggles -> Bcd_out=0, Err_out=0, Frame_vld=0, Busy=0.
//   Release reset -> no pulse for at least 2+STABLE_CYC clocks.
// 2 Scan "1234": DIGITS=4, each digit held 20 clks, Dig_n=1110/1101/1011/0111 with patterns 4,3,2,1.
//   Required: Frame_vld once after the 4th capture; Bcd_out=16'h1234, Err_out=0.
// 3 Glitch: digit 0 pattern 0000001 with a 1-clk flip to 1001111 at synced cnt=5.
//   Required: counter restarts; capture occurs STABLE_CYC clks after the flip; nibble 0, no capture of 1.
// 4 Bad glyph/blank: digit 2 shows 1111111, others legal "9870" -> Bcd_out=16'h9F70... (digit2=F), Err_out=4'b0100.
// 5 Invalid select: Dig_n=1100 or 1111 in the middle of settling -> IDLE, Busy=0, no capture.
//   Returning to 1110 needs a full STABLE_CYC before capture.
// 6 Long hold and overwrite: digit 1 held 100 clks -> exactly one capture; seen unchanged on re-show.
//   Re-show digit 1 with a new value before the frame completes -> the published frame carries the newer value.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Reads back a multiplexed, active-low 7-segment bus and recovers the BCD
//   value on display. It is the inverse of the BCD-to-segment driver and is
//   used for self-check and loop-back of the display path. A digit is
//   captured only after its synced pattern has been steady for STABLE_CYC
//   samples. A frame is published once every digit has been captured.
//
// Parameters
//   DIGITS      number of multiplexed digits (1..8)
//   STABLE_CYC  consecutive identical synced samples needed to capture (2..15)
//
// Ports
//   Clk        system clock, rising edge
//   Rst_n      asynchronous active-low reset
//   Seg_n      segment lines, Seg_n[6]=a .. Seg_n[0]=g, 0 = lit (async to Clk)
//   Dig_n      active-low one-hot digit selects, bit i = digit i (0 = LSD)
//   Bcd_out    last published value, nibble i = digit i
//   Err_out    bit i set when digit i held an illegal glyph in the last frame
//   Frame_vld  1-cycle pulse when Bcd_out/Err_out update
//   Busy       1 while a digit pattern is settling
module seg_scan_decoder #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 8
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [6:0]            Seg_n,
  input  logic [DIGITS-1:0]     Dig_n,
  output logic [4*DIGITS-1:0]   Bcd_out,
  output logic [DIGITS-1:0]     Err_out,
  output logic                  Frame_vld,
  output logic                  Busy
);

  localparam int              IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]      CNT_CAP = 4'(STABLE_CYC);
  localparam logic [DIGITS-1:0] DIG_ONE = DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  // Pattern -> {err, nibble}; anything that is not a 0-9 glyph maps to F.
  function automatic logic [4:0] decode_glyph(input logic [6:0] p);
    case (p)
      7'b0000001: return 5'h00;
      7'b1001111: return 5'h01;
      7'b0010010: return 5'h02;
      7'b0000110: return 5'h03;
      7'b1001100: return 5'h04;
      7'b0100100: return 5'h05;
      7'b0100000: return 5'h06;
      7'b0001111: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0000100: return 5'h09;
      default:    return 5'h1F;
    endcase
  endfunction

  // Exactly one select low: the inverted vector is a nonzero power of two.
  function automatic logic sel_valid(input logic [DIGITS-1:0] d);
    logic [DIGITS-1:0] a;
    a = ~d;
    return (a != '0) && ((a & (a - DIG_ONE)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] sel_index(input logic [DIGITS-1:0] d);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (!d[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  logic [6:0]          seg_p0, seg_p1;
  logic [DIGITS-1:0]   dig_p0, dig_p1;
  state_t              state;
  logic [6:0]          lat_seg;
  logic [DIGITS-1:0]   lat_dig;
  logic [3:0]          cnt;
  logic [DIGITS-1:0]   seen;
  logic [4*DIGITS-1:0] shadow_bcd;
  logic [DIGITS-1:0]   shadow_err;

  logic                sel_ok;
  logic [IDX_W-1:0]    sel_idx;
  logic                same;
  logic [4:0]          glyph;
  logic                capture;
  logic                publish;
  logic [DIGITS-1:0]   seen_next;

  // ---- stage p0/p1: two-flop synchronizers, idle bus = all ones ----
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      seg_p0 <= '1;
      seg_p1 <= '1;
      dig_p0 <= '1;
      dig_p1 <= '1;
    end else begin
      seg_p0 <= Seg_n;
      seg_p1 <= seg_p0;
      dig_p0 <= Dig_n;
      dig_p1 <= dig_p0;
    end
  end

  // ---- stage p2: settle/capture decisions on synced values ----
  always_comb begin
    sel_ok  = sel_valid(dig_p1);
    sel_idx = sel_index(dig_p1);
    same    = (seg_p1 == lat_seg) && (dig_p1 == lat_dig);
    glyph   = decode_glyph(seg_p1);
    // The sample that brings cnt to STABLE_CYC is the capture sample.
    capture = (state == SETTLE) && sel_ok && same && (cnt == CNT_CAP - 4'd1);
    publish = &seen;
    // Publish clears seen first so a same-edge capture starts the next frame.
    seen_next = publish ? '0 : seen;
    if (capture) seen_next = seen_next | (DIG_ONE << sel_idx);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      lat_seg    <= '1;
      lat_dig    <= '1;
      cnt        <= '0;
      Busy       <= 1'b0;
      seen       <= '0;
      shadow_bcd <= '0;
      shadow_err <= '0;
      Bcd_out    <= '0;
      Err_out    <= '0;
      Frame_vld  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_ok) begin
            state   <= SETTLE;
            lat_seg <= seg_p1;
            lat_dig <= dig_p1;
            cnt     <= 4'd1;
            Busy    <= 1'b1;
          end
        end
        SETTLE: begin
          if (!sel_ok) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
          end else if (!same) begin
            lat_seg <= seg_p1;
            lat_dig <= dig_p1;
            cnt     <= 4'd1;
          end else begin
            cnt <= cnt + 4'd1;
            if (capture) begin
              state <= HOLD;
              Busy  <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (!sel_ok) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!same) begin
            state   <= SETTLE;
            lat_seg <= seg_p1;
            lat_dig <= dig_p1;
            cnt     <= 4'd1;
            Busy    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          Busy  <= 1'b0;
        end
      endcase

      if (capture) begin
        shadow_bcd[4*sel_idx +: 4] <= glyph[3:0];
        shadow_err[sel_idx]        <= glyph[4];
      end

      seen      <= seen_next;
      Frame_vld <= publish;
      if (publish) begin
        Bcd_out <= shadow_bcd;
        Err_out <= shadow_err;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Scoreboard bench for seg_scan_decoder (DIGITS=4, STABLE_CYC=8). Expected
//   frames are queued when a scan is driven and compared when Frame_vld fires.
module tb_seg_scan_decoder;

  localparam int DIGITS     = 4;
  localparam int STABLE_CYC = 8;

  logic                Clk = 1'b0;
  logic                Rst_n;
  logic [6:0]          Seg_n;
  logic [DIGITS-1:0]   Dig_n;
  logic [4*DIGITS-1:0] Bcd_out;
  logic [DIGITS-1:0]   Err_out;
  logic                Frame_vld;
  logic                Busy;

  seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Seg_n     (Seg_n),
    .Dig_n     (Dig_n),
    .Bcd_out   (Bcd_out),
    .Err_out   (Err_out),
    .Frame_vld (Frame_vld),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  logic [6:0] glyph [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100};
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  err;
  } frame_t;

  frame_t exp_q[$];
  int     n_vec  = 0;
  int     n_bad  = 0;
  int     frames = 0;
  logic   prev_vld = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic show(input int idx, input logic [6:0] pat, input int clks);
    Seg_n = pat;
    Dig_n = 4'(~(4'b0001 << idx));
    repeat (clks) @(negedge Clk);
  endtask

  task automatic blank(input int clks);
    Seg_n = BLANK;
    Dig_n = 4'hF;
    repeat (clks) @(negedge Clk);
  endtask

  task automatic expect_frame(input logic [15:0] bcd, input logic [3:0] err);
    frame_t f;
    f.bcd = bcd;
    f.err = err;
    exp_q.push_back(f);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge Clk);
    check_val(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Frame monitor: pop and compare on every published frame.
  always @(negedge Clk) begin
    frame_t f;
    if (Frame_vld) begin
      frames++;
      check_val("vld_width", 32'(prev_vld), 32'd0);
      if (exp_q.size() == 0) begin
        check_val("unexp_frame", 32'(Bcd_out), 32'hFFFFFFFF);
      end else begin
        f = exp_q.pop_front();
        check_val("frame_bcd", 32'(Bcd_out), 32'(f.bcd));
        check_val("frame_err", 32'(Err_out), 32'(f.err));
      end
    end
    prev_vld = Frame_vld;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    Rst_n = 1'b0;
    Seg_n = BLANK;
    Dig_n = 4'hF;

    // Reset held while the bus toggles.
    repeat (6) begin
      @(negedge Clk);
      Seg_n = 7'($urandom);
      Dig_n = 4'($urandom);
      check_val("rst_bcd",  32'(Bcd_out),   32'd0);
      check_val("rst_err",  32'(Err_out),   32'd0);
      check_val("rst_vld",  32'(Frame_vld), 32'd0);
      check_val("rst_busy", 32'(Busy),      32'd0);
    end
    Rst_n = 1'b1;
    repeat (2 + STABLE_CYC + 2) begin
      @(negedge Clk);
      Seg_n = 7'($urandom);
      Dig_n = 4'($urandom);
      check_val("post_rst_vld", 32'(Frame_vld), 32'd0);
    end
    blank(5);

    // Scan "1234", with capture-latency check on digit 0.
    expect_frame(16'h1234, 4'b0000);
    Seg_n = glyph[4];
    Dig_n = 4'b1110;
    repeat (STABLE_CYC + 1) @(negedge Clk);
    check_val("lat_busy_hi", 32'(Busy), 32'd1);
    @(negedge Clk);
    check_val("lat_busy_lo", 32'(Busy), 32'd0);
    repeat (10) @(negedge Clk);
    show(1, glyph[3], 20);
    show(2, glyph[2], 20);
    show(3, glyph[1], 20);
    blank(5);
    drain("drain_1234");

    // One-clock glitch on digit 0 restarts the stability count.
    expect_frame(16'h7650, 4'b0000);
    Seg_n = glyph[0];
    Dig_n = 4'b1110;
    repeat (4) @(negedge Clk);
    Seg_n = glyph[1];
    @(negedge Clk);
    Seg_n = glyph[0];
    repeat (9) @(negedge Clk);
    check_val("glitch_busy_hi", 32'(Busy), 32'd1);
    repeat (2) @(negedge Clk);
    check_val("glitch_busy_lo", 32'(Busy), 32'd0);
    repeat (4) @(negedge Clk);
    show(1, glyph[5], 20);
    show(2, glyph[6], 20);
    show(3, glyph[7], 20);
    blank(5);
    drain("drain_glitch");

    // Blank glyph on digit 2 is flagged and decodes to F.
    expect_frame(16'h9F70, 4'b0100);
    show(0, glyph[0], 20);
    show(1, glyph[7], 20);
    show(2, BLANK,    20);
    show(3, glyph[9], 20);
    blank(5);
    drain("drain_badglyph");

    // Invalid selects mid-settle drop to IDLE and force a full recount.
    expect_frame(16'h8765, 4'b0000);
    for (int d = 0; d < 2; d++) begin
      Seg_n = glyph[5 + d];
      Dig_n = 4'(~(4'b0001 << d));
      repeat (4) @(negedge Clk);
      Dig_n = (d == 0) ? 4'b1100 : 4'b1111;
      repeat (6) @(negedge Clk);
      check_val("inv_busy", 32'(Busy), 32'd0);
      Dig_n = 4'(~(4'b0001 << d));
      repeat (9) @(negedge Clk);
      check_val("recount_busy_hi", 32'(Busy), 32'd1);
      repeat (2) @(negedge Clk);
      check_val("recount_busy_lo", 32'(Busy), 32'd0);
      repeat (9) @(negedge Clk);
    end
    show(2, glyph[7], 20);
    show(3, glyph[8], 20);
    blank(5);
    drain("drain_invsel");

    // Long hold: one capture only, no frame until all digits seen.
    expect_frame(16'h6543, 4'b0000);
    f0 = frames;
    show(0, glyph[3], 20);
    show(1, glyph[4], 100);
    show(2, glyph[5], 20);
    check_val("hold_no_frame", 32'(frames), 32'(f0));
    show(3, glyph[6], 20);
    blank(5);
    drain("drain_hold");

    // Overwrite: re-shown digit 1 carries its newer value into the frame.
    expect_frame(16'h4381, 4'b0000);
    f0 = frames;
    show(0, glyph[1], 20);
    show(1, glyph[2], 20);
    show(2, glyph[3], 20);
    show(1, glyph[8], 20);
    check_val("ovw_no_frame", 32'(frames), 32'(f0));
    show(3, glyph[4], 20);
    blank(5);
    drain("drain_overwrite");

    // Reset mid-frame discards partial captures.
    show(0, glyph[9], 20);
    show(1, glyph[9], 20);
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    check_val("midrst_bcd", 32'(Bcd_out), 32'd0);
    Rst_n = 1'b1;
    f0 = frames;
    show(2, glyph[1], 20);
    show(3, glyph[2], 20);
    check_val("midrst_no_frame", 32'(frames), 32'(f0));
    expect_frame(16'h2143, 4'b0000);
    show(0, glyph[3], 20);
    show(1, glyph[4], 20);
    blank(5);
    drain("drain_midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
